// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised UART receiver with a one-entry output buffer.
//
// Frame: start bit, DATA_W data bits (LSB- or MSB-first), optional parity
// bit (none/even/odd/mark/space), one or two stop bits. Frame timing and
// format are captured while idle and held for the whole frame.
//
// Optional build macro:
//   UART_RX_MAJORITY_VOTE_EN  -- when defined, each bit decision is the
//                                2-of-3 vote of the last three rx_s values;
//                                otherwise a single sample is used.
//
// Parameters:
//   DATA_W  data bits per frame (5..9)
//   CNT_W   width of the bit-period counter
//
// Ports:
//   i_clk                     clock, rising edge
//   i_rst                     synchronous active-high reset
//   i_bit_length              clocks per bit minus 1 (clamped to >= 3)
//   i_parity_mode             0 none,1 even,2 odd,3 mark,4 space,5..7 none
//   i_two_stop                check a second stop bit
//   i_msb_first               first received data bit is the MSB
//   i_hw_flow_control_enable  hold o_rts low while the buffer is full
//   i_rx                      asynchronous serial input, idle high
//   i_ready                   consumer accepts o_data
//   o_data                    received word
//   o_valid                   o_data and per-word flags valid
//   o_frame_error             a checked stop bit sampled 0
//   o_parity_error            parity bit mismatch
//   o_break                   data, parity and first stop bit all 0
//   o_overrun                 sticky: a word was dropped on a full buffer
//   o_busy                    frame in progress
//   o_rts                     ready-to-send
module uart_rx_param #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CNT_W-1:0]  i_bit_length,
  input  logic [2:0]        i_parity_mode,
  input  logic              i_two_stop,
  input  logic              i_msb_first,
  input  logic              i_hw_flow_control_enable,
  input  logic              i_rx,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_error,
  output logic              o_parity_error,
  output logic              o_break,
  output logic              o_overrun,
  output logic              o_busy,
  output logic              o_rts
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2
  } state_t;

  localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);
  localparam logic [CNT_W-1:0] MIN_BL   = CNT_W'(3);

  // ---------------------------------------------------------------------
  // Line synchroniser. flush_q marks when rx_s reflects the real line
  // rather than the reset value of the flops.
  // ---------------------------------------------------------------------
  logic       sync1_q, rx_s_q;
  logic [1:0] flush_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      flush_q <= 2'b00;
    end else begin
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
      flush_q <= {flush_q[0], 1'b1};
    end
  end

  // Bit decision: single sample, or vote over the last three line values.
  logic bit_val;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rxh1_q, rxh2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rxh1_q <= 1'b1;
      rxh2_q <= 1'b1;
    end else begin
      rxh1_q <= rx_s_q;
      rxh2_q <= rxh1_q;
    end
  end

  assign bit_val = (rx_s_q & rxh1_q) | (rx_s_q & rxh2_q) | (rxh1_q & rxh2_q);
`else
  assign bit_val = rx_s_q;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   bl_q, bl_d;
  logic [2:0]         pm_q, pm_d;
  logic               two_q, two_d;
  logic               msb_q, msb_d;
  logic               arm_q, arm_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic               zero_q, zero_d;   // every sample so far was 0
  logic               fe_q, fe_d;
  logic               pe_q, pe_d;
  logic               brk_q, brk_d;
  logic               done;             // final stop bit sampled this cycle

  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ofe_q, ofe_d;
  logic               ope_q, ope_d;
  logic               obrk_q, obrk_d;
  logic               ovr_q, ovr_d;

  logic at_half, at_target, has_par, exp_par;

  assign at_half   = (cnt_q == (bl_q >> 1));
  assign at_target = (cnt_q == bl_q);
  assign has_par   = (pm_q != 3'd0);

  always_comb begin
    exp_par = 1'b0;
    case (pm_q)
      3'd1:    exp_par = ^shift_q;
      3'd2:    exp_par = ~^shift_q;
      3'd3:    exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Next-state / datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bl_d     = bl_q;
    pm_d     = pm_q;
    two_d    = two_q;
    msb_d    = msb_q;
    arm_d    = arm_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    zero_d   = zero_q;
    fe_d     = fe_q;
    pe_d     = pe_q;
    brk_d    = brk_q;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        bl_d     = (i_bit_length < MIN_BL) ? MIN_BL : i_bit_length;
        pm_d     = (i_parity_mode > 3'd4) ? 3'd0 : i_parity_mode;
        two_d    = i_two_stop;
        msb_d    = i_msb_first;
        bitcnt_d = '0;
        zero_d   = 1'b1;
        fe_d     = 1'b0;
        pe_d     = 1'b0;
        brk_d    = 1'b0;
        // Only a high-to-low transition seen while idle starts a frame, so
        // a line that is already low (after reset or a break) is ignored.
        if (flush_q[1] && rx_s_q) arm_d = 1'b1;
        if (arm_q && !rx_s_q) begin
          state_d = S_START;
          arm_d   = 1'b0;
        end
      end

      S_START: begin
        if (at_half) begin
          cnt_d   = '0;
          state_d = bit_val ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (at_target) begin
          cnt_d    = '0;
          shift_d  = msb_q ? {shift_q[DATA_W-2:0], bit_val}
                           : {bit_val, shift_q[DATA_W-1:1]};
          zero_d   = zero_q & ~bit_val;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == LAST_BIT) state_d = has_par ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        if (at_target) begin
          cnt_d   = '0;
          pe_d    = (bit_val != exp_par);
          zero_d  = zero_q & ~bit_val;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (at_target) begin
          cnt_d = '0;
          fe_d  = fe_q | ~bit_val;
          brk_d = zero_q & ~bit_val;
          if (two_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end
      end

      S_STOP2: begin
        if (at_target) begin
          cnt_d   = '0;
          fe_d    = fe_q | ~bit_val;
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer. A handshake frees the slot first, so a word completing
  // on the same cycle as a handshake is loaded without an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ofe_d   = ofe_q;
    ope_d   = ope_q;
    obrk_d  = obrk_q;
    ovr_d   = ovr_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        ofe_d   = fe_d;
        ope_d   = pe_q;
        obrk_d  = brk_d;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bl_q     <= MIN_BL;
      pm_q     <= 3'd0;
      two_q    <= 1'b0;
      msb_q    <= 1'b0;
      arm_q    <= 1'b0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      zero_q   <= 1'b1;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
      brk_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ofe_q    <= 1'b0;
      ope_q    <= 1'b0;
      obrk_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bl_q     <= bl_d;
      pm_q     <= pm_d;
      two_q    <= two_d;
      msb_q    <= msb_d;
      arm_q    <= arm_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      zero_q   <= zero_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      brk_q    <= brk_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ofe_q    <= ofe_d;
      ope_q    <= ope_d;
      obrk_q   <= obrk_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_frame_error  = ofe_q;
  assign o_parity_error = ope_q;
  assign o_break        = obrk_q;
  assign o_overrun      = ovr_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_rts          = (state_q == S_IDLE) &&
                          (!i_hw_flow_control_enable || !valid_q);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_W: default 8; data bits per frame, legal 5..9.
REQ-002 SHALL have parameter CNT_W: default 16; width of the bit-period counter.
REQ-003 SHALL have port i_clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_bit_length  in  CNT_W  clocks per bit minus 1; values below 3 treated as 3.
REQ-006 SHALL have port i_parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5..7 treated as none.
REQ-007 SHALL have port i_two_stop  in  1  1 = two stop bits checked.
REQ-008 SHALL have port i_msb_first  in  1  1 = first received data bit is MSB.
REQ-009 SHALL have port i_hw_flow_control_enable  in  1  gates o_rts with buffer state.
REQ-010 SHALL have port i_rx  in  1  asynchronous serial line, idle high.
REQ-011 SHALL have port i_ready  in  1  consumer accepts o_data.
REQ-012 SHALL have port o_data  out  DATA_W  received word.
REQ-013 SHALL have port o_valid  out  1  o_data and error flags valid.
REQ-014 SHALL have ports o_frame_error, o_parity_error, o_break  out  1 each  per-word status, qualified by o_valid.
REQ-015 SHALL have port o_overrun  out  1  sticky overrun flag.
REQ-016 SHALL have ports o_busy, o_rts  out  1 each  frame in progress; ready-to-send.

Function
REQ-017 SHALL pass i_rx through a 2-flop synchroniser; all line decisions use the synchronised value rx_s.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, STOP2.
REQ-019 SHALL in IDLE latch i_bit_length, i_parity_mode, i_two_stop, i_msb_first every cycle and enter START on rx_s==0; the latched values hold for the whole frame.
REQ-020 SHALL in START count to bit_length>>1; at that count, if the sampled bit is 1 (false start) return to IDLE with no output, else clear the counter and enter DATA.
REQ-021 SHALL in DATA, PARITY, STOP, STOP2 sample one bit when the counter equals bit_length (mid-bit), then clear the counter.
REQ-022 SHALL leave DATA after DATA_W samples, going to PARITY if the mode is not none, else to STOP; go from PARITY to STOP; from STOP to STOP2 if two-stop, else to IDLE; from STOP2 to IDLE.
REQ-023 SHALL shift data LSB-first by default, or MSB-first when i_msb_first was latched as 1.
REQ-024 SHALL flag parity_error when the received parity differs from the expected value: even = XOR of data, odd = its inverse, mark = 1, space = 0.
REQ-025 SHALL flag frame_error when any checked stop bit samples 0.
REQ-026 SHALL flag break when all data bits, the parity bit (if any) and the first stop bit sample 0; break implies frame_error.
REQ-027 SHALL load the one-entry output buffer (o_data plus flags) and set o_valid on the cycle after the final stop-bit sample.
REQ-028 SHALL clear o_valid on a cycle where o_valid and i_ready are both 1.
REQ-029 SHALL, when a frame completes while o_valid is 1 and i_ready is 0, discard the new word, keep the buffer, and set o_overrun.
REQ-030 SHALL, on a completion that coincides with o_valid&&i_ready, load the new word with no overrun.
REQ-031 SHALL clear o_overrun on the next o_valid&&i_ready handshake.
REQ-032 SHALL drive o_busy = (state != IDLE).
REQ-033 SHALL drive o_rts = (state==IDLE) && (!i_hw_flow_control_enable || !o_valid).
REQ-034 SHALL ignore i_ready while o_valid is 0.

Reset
REQ-035 SHALL on i_rst set: state IDLE, counter 0, synchroniser flops 1, o_data 0, o_valid 0, all flags 0, o_busy 0, o_rts 1 (by the REQ-033 equation).
REQ-036 SHALL on i_rst mid-frame abandon the frame with no output, and take the next frame only after a fresh falling edge.

Configuration
REQ-037 SHALL honour macro UART_RX_MAJORITY_VOTE_EN: when defined, each bit value (including the start check) is the 2-of-3 majority of rx_s at counter values target-2, target-1 and target; when undefined, each bit is the single rx_s sample at target.

Verification
REQ-038 SHALL cover: DATA_W=8, bit_length=15, no parity, 1 stop, LSB-first, byte 0xA5 -> o_valid=1 with o_data=0xA5 and no errors, 1 cycle after the stop-bit mid-sample.
REQ-039 SHALL cover: even parity, 0x03 sent with parity bit 1 -> o_parity_error=1; repeated with odd mode -> 0.
REQ-040 SHALL cover: i_rx held low for 12 bit times -> o_break=1 and o_frame_error=1.
REQ-041 SHALL cover: two frames with i_ready=0 -> first word retained, o_overrun=1; after i_ready=1 for one cycle -> o_valid=0 and o_overrun=0.
REQ-042 SHALL cover: 3-cycle low glitch on an idle line -> return to IDLE and no o_valid; with the macro on, a 1-cycle mid-bit glitch does not corrupt the bit.
REQ-043 SHALL cover: DATA_W=9, MSB-first, two stop bits, i_rst asserted mid-frame -> all outputs return to reset values, and the next 0x1C3 frame is received correctly.
